// File: rtl/cpu_prog_loader_if.sv
// Byte-stream input and CPU RAM write port of the program loader.
//   in_valid / in_data / in_ready : program byte stream (valid/ready handshake)
//   load_ram / load_addr / load_data : one-cycle write strobe into CPU RAM
// The slave modport is the loader's view; the master modport is the
// environment that feeds bytes in and observes RAM writes.
interface cpu_prog_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              load_ram;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output load_ram,
        output load_addr,
        output load_data
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  load_ram,
        input  load_addr,
        input  load_data
    );
endinterface

// File: rtl/cpu_prog_loader.sv
// Program loader feeding simplecpu's RAM-load port.
// Receives NBYTES program bytes followed by one checksum byte, writes each
// program byte to consecutive RAM addresses from 0, and releases the CPU
// from reset only when the bytes plus checksum sum to zero (mod 2**DATA_W).
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous active-low reset
//   start     : one-cycle pulse, begins or restarts a load from any state
//   bus       : byte stream in / RAM write strobe out (slave modport)
//   cpu_reset : 0 holds the CPU in reset, 1 lets it run
//   busy      : load in progress (LOAD or CHECK)
//   done      : last load passed its checksum
//   err       : last load failed its checksum
module cpu_prog_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int NBYTES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    cpu_prog_loader_if.slave       bus,
    output logic                   cpu_reset,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    // One extra bit so that NBYTES == 2**ADDR_W is representable.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        RUN   = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  count_r;
    logic [DATA_W-1:0] sum_r;
    logic              load_ram_r;
    logic [ADDR_W-1:0] load_addr_r;
    logic [DATA_W-1:0] load_data_r;
    logic              cpu_reset_r;
    logic              done_r;
    logic              err_r;
    logic              in_ready_s;
    logic              accept_s;

    // Running two's-complement checksum step (modulo 2**DATA_W).
    function automatic logic [DATA_W-1:0] sum_add(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        return a + b;
    endfunction

    assign in_ready_s    = (state_r == LOAD) || (state_r == CHECK);
    assign accept_s      = bus.in_valid && in_ready_s;
    assign bus.in_ready  = in_ready_s;
    assign bus.load_ram  = load_ram_r;
    assign bus.load_addr = load_addr_r;
    assign bus.load_data = load_data_r;
    assign cpu_reset     = cpu_reset_r;
    assign busy          = in_ready_s;
    assign done          = done_r;
    assign err           = err_r;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; start overrides everything and discards any
    // byte handshaked in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        if (start) begin
            state_nxt_s = LOAD;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = IDLE;
                end
                LOAD: begin
                    if (accept_s && (count_r == LAST_IDX)) begin
                        state_nxt_s = CHECK;
                    end else begin
                        state_nxt_s = LOAD;
                    end
                end
                CHECK: begin
                    if (!accept_s) begin
                        state_nxt_s = CHECK;
                    end else if (sum_add(sum_r, bus.in_data) == {DATA_W{1'b0}}) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = ERROR;
                    end
                end
                RUN: begin
                    state_nxt_s = RUN;
                end
                ERROR: begin
                    state_nxt_s = ERROR;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // Datapath: counter, checksum, RAM strobe and status outputs.
    // Status flags follow the next state so they line up with the state
    // register; the RAM strobe is a single-cycle pulse registered one cycle
    // after acceptance, so a pending strobe still fires under start but not
    // under reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r     <= '0;
            sum_r       <= '0;
            load_ram_r  <= 1'b0;
            load_addr_r <= '0;
            load_data_r <= '0;
            cpu_reset_r <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            load_ram_r <= 1'b0;
            if (start) begin
                count_r <= '0;
                sum_r   <= '0;
            end else if ((state_r == LOAD) && accept_s) begin
                load_ram_r  <= 1'b1;
                load_addr_r <= count_r[ADDR_W-1:0];
                load_data_r <= bus.in_data;
                count_r     <= count_r + CNT_W'(1);
                sum_r       <= sum_add(sum_r, bus.in_data);
            end
            cpu_reset_r <= (state_nxt_s == RUN);
            done_r      <= (state_nxt_s == RUN);
            err_r       <= (state_nxt_s == ERROR);
        end
    end
endmodule

// File: tb/tb_cpu_prog_loader.sv
// Self-checking bench for cpu_prog_loader: a background monitor pops the
// expected {addr,data} of each RAM write from a scoreboard queue filled by
// the byte driver; each scenario task checks status outputs inline.
module tb_cpu_prog_loader;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int NBYTES = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic cpu_reset, busy, done, err;

    cpu_prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    cpu_prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NBYTES(NBYTES)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    logic [11:0] exp_q[$];
    logic [3:0] addr_exp = 4'd0;
    logic [7:0] img[NBYTES];

    // Scoreboard monitor: every strobe must match the queue head and never
    // coincide with a released CPU.
    task automatic monitor();
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (bus.load_ram === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_strobe got addr=%0h data=%02h expected no strobe",
                             bus.load_addr, bus.load_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.load_addr, bus.load_data} !== e) begin
                        n_fail++;
                        $display("FAIL ram_write got addr=%0h data=%02h expected addr=%0h data=%02h",
                                 bus.load_addr, bus.load_data, e[11:8], e[7:0]);
                    end
                end
                n_cmp++;
                if (cpu_reset !== 1'b0) begin
                    n_fail++;
                    $display("FAIL strobe_while_running got cpu_reset=%b expected 0", cpu_reset);
                end
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        addr_exp = 4'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Drive one byte; program bytes push their expected RAM write.
    task automatic send_byte(input logic [7:0] d, input bit is_data);
        int waitc = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (bus.in_ready !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (bus.in_ready !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout got in_ready=%b expected 1 within 50 cycles", bus.in_ready);
        end else if (is_data) begin
            exp_q.push_back({addr_exp, d});
            addr_exp = addr_exp + 4'd1;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Send img[] with optional stalls, then the checksum byte.
    task automatic send_image(input logic [7:0] chk, input int stall_max);
        for (int i = 0; i < NBYTES; i++) begin
            send_byte(img[i], 1'b1);
            if (stall_max > 0) idle((i % 2) + $urandom_range(0, stall_max));
        end
        send_byte(chk, 1'b0);
    endtask

    function automatic logic [7:0] good_chk();
        logic [7:0] s = 8'h00;
        for (int i = 0; i < NBYTES; i++) s = s + img[i];
        return 8'h00 - s;
    endfunction

    task automatic check_status(input string name, input logic exp_cr, input logic exp_done,
                                input logic exp_err, input logic exp_busy);
        @(negedge clk);
        n_cmp++;
        if ({cpu_reset, done, err, busy} !== {exp_cr, exp_done, exp_err, exp_busy}) begin
            n_fail++;
            $display("FAIL %s got cpu_reset/done/err/busy=%b%b%b%b expected %b%b%b%b", name,
                     cpu_reset, done, err, busy, exp_cr, exp_done, exp_err, exp_busy);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_writes got %0d outstanding writes expected 0", name, exp_q.size());
        end
    endtask

    task automatic load_test_image();
        img[0] = 8'h51; img[1] = 8'h80; img[2] = 8'h90;
        for (int i = 3; i < NBYTES; i++) img[i] = 8'h00;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.load_ram, bus.load_addr, bus.load_data, cpu_reset, bus.in_ready, busy, done, err} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got ram=%b a=%0h d=%02h cr=%b rdy=%b busy=%b done=%b err=%b expected all 0",
                     bus.load_ram, bus.load_addr, bus.load_data, cpu_reset, bus.in_ready, busy, done, err);
        end
        reset = 1'b1;
    endtask

    task automatic test_good_load();
        load_test_image();
        pulse_start();
        send_image(8'h9F, 0);
        check_status("good_load", 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_bad_checksum();
        load_test_image();
        pulse_start();
        send_image(8'h9E, 0);
        check_status("bad_checksum", 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        check_status("error_hold", 1'b0, 1'b0, 1'b1, 1'b0);
        pulse_start();
        check_status("error_cleared", 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_throttled();
        for (int i = 0; i < NBYTES; i++) img[i] = 8'($urandom_range(0, 255));
        pulse_start();
        send_image(good_chk(), 2);
        check_status("throttled", 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_restart();
        for (int i = 0; i < NBYTES; i++) img[i] = 8'(i * 7 + 3);
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b1);
        // Restart while byte 5's strobe is pending and a new byte is offered.
        @(negedge clk);
        start = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 8'hEE;
        @(posedge clk);
        #1 start = 1'b0;
        bus.in_valid = 1'b0;
        addr_exp = 4'd0;
        send_image(good_chk(), 0);
        check_status("restart", 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        load_test_image();
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(img[i], 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data = 8'h77;
        reset = 1'b0;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.load_ram, bus.load_addr, bus.load_data, cpu_reset, bus.in_ready, busy, done, err} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_mid got ram=%b a=%0h d=%02h cr=%b rdy=%b busy=%b done=%b err=%b expected all 0",
                     bus.load_ram, bus.load_addr, bus.load_data, cpu_reset, bus.in_ready, busy, done, err);
        end
        idle(3);
        check_status("reset_mid_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_run_restart();
        load_test_image();
        pulse_start();
        send_image(8'h9F, 0);
        check_status("run_before_restart", 1'b1, 1'b1, 1'b0, 1'b0);
        pulse_start();
        @(negedge clk);
        n_cmp++;
        if ({cpu_reset, done, bus.in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL run_restart got cpu_reset/done/in_ready=%b%b%b expected 001",
                     cpu_reset, done, bus.in_ready);
        end
        send_image(8'h9F, 0);
        check_status("reload", 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_throttled();
        test_restart();
        test_reset_mid();
        test_run_restart();
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
